instr_fetch_unit: RTL and testbench

//  Requester side of the sdram controller instruction port: drives instr_enable/instr_addr, captures instr_result.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its fetch buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_LO,
        WAIT_HI
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] raw_pc);
        return raw_pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush clears it and overrides push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !full && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: sequential PC generation, one outstanding fetch, buffered output, redirect/squash.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ADDR_W     = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_enable,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [31:0]       instr_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       stat_fetches,
    output logic [31:0]       stat_squashes
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e state;
    fetch_state_e next_state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         squash;
    logic         next_squash;

    logic             accept;
    logic             response;
    logic             push;
    logic             pop;
    logic             has_free;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign accept     = (state == REQ) && instr_valid;
    assign response   = (state == WAIT_HI) && instr_valid;
    assign push       = response && !squash && !redirect_valid && !fifo_full;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign has_free   = (fifo_count != DEPTH_C);
    assign push_entry = '{pc: pc, instr: instr_result};

    assign instr_enable = (state == REQ);
    assign instr_addr   = instr_enable ? pc[ADDR_W-1:0] : '0;
    assign out_valid    = !fifo_empty;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            squash <= 1'b0;
        end else begin
            state  <= next_state;
            pc     <= next_pc;
            squash <= next_squash;
        end
    end

    // A redirect always wins the PC; an in-flight fetch is marked squashed unless it completes this cycle.
    always_comb begin
        next_state  = state;
        next_pc     = pc;
        next_squash = squash;
        case (state)
            IDLE: begin
                if (!redirect_valid && has_free) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    next_state = WAIT_LO;
                    if (redirect_valid) begin
                        next_squash = 1'b1;
                    end
                end else if (redirect_valid) begin
                    next_state = IDLE;
                end
            end
            WAIT_LO: begin
                if (!instr_valid) begin
                    next_state = WAIT_HI;
                end
                if (redirect_valid) begin
                    next_squash = 1'b1;
                end
            end
            WAIT_HI: begin
                if (instr_valid) begin
                    next_state  = IDLE;
                    next_squash = 1'b0;
                    if (!squash) begin
                        next_pc = pc + PC_STEP;
                    end
                end else if (redirect_valid) begin
                    next_squash = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (redirect_valid) begin
            next_pc = align_pc(redirect_pc);
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    // A response that arrives together with a redirect is discarded, so it counts as squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (push) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (response && (squash || redirect_valid)) begin
                squash_cnt <= squash_cnt + 32'd1;
            end
        end
    end

    assign stat_fetches  = fetch_cnt;
    assign stat_squashes = squash_cnt;
`else
    assign stat_fetches  = '0;
    assign stat_squashes = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: controller model, scoreboard queue, redirect vector table.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int          ADDR_W   = 25;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_enable;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid = 1'b1;
    logic [31:0]       instr_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic [31:0]       stat_fetches;
    logic [31:0]       stat_squashes;

    instr_fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RESET_PC),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_enable   (instr_enable),
        .instr_addr     (instr_addr),
        .instr_valid    (instr_valid),
        .instr_result   (instr_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stat_fetches   (stat_fetches),
        .stat_squashes  (stat_squashes)
    );

    always #5 clk = ~clk;

    typedef enum int {C_READY, C_OVER, C_BUSY, C_RESP} ctl_e;
    typedef enum int {K_IDLE, K_BUSY, K_REQ, K_BUSY3, K_OVER, K_POPS, K_ACCEPTS} cond_e;

    typedef struct {
        logic [31:0] rpc;
        cond_e       when;
        logic [31:0] pc0;
        logic [31:0] instr0;
        logic [31:0] pc1;
        logic [31:0] instr1;
    } redir_vec_t;

    int checks = 0;
    int failures = 0;

    ctl_e              cst = C_READY;
    int                busy_cnt = 0;
    int                ready_delay = 0;
    logic [ADDR_W-1:0] acc_addr = '0;
    logic [ADDR_W-1:0] last_acc_addr = '0;
    logic              en_s = 1'b0;
    logic              v_s = 1'b0;
    logic              redir_s = 1'b0;
    logic [ADDR_W-1:0] addr_s = '0;
    logic [31:0]       redir_pc_s = '0;
    logic [31:0]       tb_pc = RESET_PC;
    logic [31:0]       flight_pc = '0;
    bit                flight_valid = 0;
    bit                flight_dropped = 0;
    bit                stalling = 0;
    logic [ADDR_W-1:0] stall_addr = '0;
    int                stall_cycles = 0;
    int                addr_unstable = 0;
    int                accepts = 0;
    int                exp_fetches = 0;
    int                exp_squashes = 0;
    fetch_entry_t      exp_q[$];
    fetch_entry_t      pop_log[$];

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h100 + 32'(a >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic resetModel();
        cst            = C_READY;
        busy_cnt       = 0;
        instr_valid    = 1'b1;
        instr_result   = '0;
        ready_delay    = 0;
        flight_valid   = 0;
        flight_dropped = 0;
        tb_pc          = RESET_PC;
        stalling       = 0;
        stall_cycles   = 0;
        addr_unstable  = 0;
        accepts        = 0;
        exp_fetches    = 0;
        exp_squashes   = 0;
        exp_q.delete();
        pop_log.delete();
    endtask

    function automatic logic [31:0] statExpected(input int count);
`ifdef FETCH_STATS_EN
        return 32'(count);
`else
        return 32'(count) & 32'h0;
`endif
    endfunction

    // Reset is asserted away from the clock edge; outputs must drop immediately.
    task automatic doReset();
        #1;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("rst_instr_enable", 32'(instr_enable), 32'h0);
        checkOutput("rst_instr_addr", 32'(instr_addr), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_stat_fetches", stat_fetches, 32'h0);
        checkOutput("rst_stat_squashes", stat_squashes, 32'h0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    function automatic bit condMet(input cond_e kind, input int arg);
        case (kind)
            K_IDLE:    return (cst == C_READY) && !instr_enable && !flight_valid;
            K_BUSY:    return (cst == C_BUSY);
            K_REQ:     return instr_enable && (cst == C_READY) && instr_valid;
            K_BUSY3:   return (cst == C_BUSY) && (busy_cnt == 3);
            K_OVER:    return (cst == C_OVER);
            K_POPS:    return pop_log.size() >= arg;
            K_ACCEPTS: return accepts >= arg;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic waitCond(input cond_e kind, input int arg, input int limit, input string name);
        int n = 0;
        while (!condMet(kind, arg) && n < limit) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(condMet(kind, arg)), 32'h1);
    endtask

    // Sample DUT outputs on the falling edge; the controller model acts on these at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("sb_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                checkOutput("sb_out_pc", out_pc, exp_q[0].pc);
                checkOutput("sb_out_instr", out_instr, exp_q[0].instr);
                if (out_ready && !redirect_valid) begin
                    pop_log.push_back(exp_q.pop_front());
                end
            end
            checkOutput("sb_stat_fetches", stat_fetches, statExpected(exp_fetches));
            checkOutput("sb_stat_squashes", stat_squashes, statExpected(exp_squashes));
        end
        en_s       = instr_enable;
        v_s        = instr_valid;
        addr_s     = instr_addr;
        redir_s    = redirect_valid;
        redir_pc_s = redirect_pc;
    end

    // Controller model: ready level, accept, one overlap cycle, busy, then a one-cycle response.
    always @(posedge clk) begin
        ctl_e cur;
        #1;
        if (rst_n) begin
            cur = cst;
            if (cur == C_READY && en_s && v_s) begin
                accepts++;
                acc_addr      = addr_s;
                last_acc_addr = addr_s;
                checkOutput("accept_addr", 32'(addr_s), 32'(tb_pc[ADDR_W-1:0]));
                flight_valid = 1;
                flight_pc    = tb_pc;
                stalling     = 0;
                cst          = C_OVER;
            end else if (cur == C_READY && en_s) begin
                if (!stalling) begin
                    stalling   = 1;
                    stall_addr = addr_s;
                end else if (addr_s != stall_addr) begin
                    addr_unstable++;
                end
                stall_cycles++;
                if (ready_delay > 0) ready_delay--;
                instr_valid = (ready_delay == 0);
            end
            if (redir_s) begin
                exp_q.delete();
                if (flight_valid) begin
                    flight_dropped = 1;
                    flight_valid   = 0;
                end
                tb_pc = redir_pc_s & ~32'h3;
            end
            case (cur)
                C_OVER: begin
                    cst         = C_BUSY;
                    busy_cnt    = 6;
                    instr_valid = 1'b0;
                end
                C_BUSY: begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        instr_valid  = 1'b1;
                        instr_result = mem_word(acc_addr);
                        cst          = C_RESP;
                    end
                end
                C_RESP: begin
                    if (flight_dropped) begin
                        exp_squashes++;
                        flight_dropped = 0;
                    end else if (flight_valid) begin
                        exp_q.push_back('{pc: flight_pc, instr: instr_result});
                        exp_fetches++;
                        tb_pc        = tb_pc + 32'd4;
                        flight_valid = 0;
                    end
                    cst         = C_READY;
                    instr_valid = (ready_delay == 0);
                end
                default: ;
            endcase
        end
    end

    initial begin
        redir_vec_t vecs[4];
        int         hi_count;
        int         a0;

        vecs[0] = '{rpc: 32'h0000_0040, when: K_BUSY, pc0: 32'h0000_0040, instr0: 32'h0000_0110,
                    pc1: 32'h0000_0044, instr1: 32'h0000_0111};
        vecs[1] = '{rpc: 32'h0000_1001, when: K_REQ,  pc0: 32'h0000_1000, instr0: 32'h0000_0500,
                    pc1: 32'h0000_1004, instr1: 32'h0000_0501};
        vecs[2] = '{rpc: 32'hFFFF_FFFE, when: K_IDLE, pc0: 32'hFFFF_FFFC, instr0: 32'h0080_00FF,
                    pc1: 32'h0000_0000, instr1: 32'h0000_0100};
        vecs[3] = '{rpc: 32'h0000_0023, when: K_BUSY, pc0: 32'h0000_0020, instr0: 32'h0000_0108,
                    pc1: 32'h0000_0024, instr1: 32'h0000_0109};

        $display("[TB] reset and sequential stream");
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitCond(K_POPS, 3, 200, "stream_timeout");
        if (pop_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("stream_pc", pop_log[i].pc, 32'(4 * i));
                checkOutput("stream_instr", pop_log[i].instr, 32'h100 + 32'(i));
            end
        end

        $display("[TB] redirect vector table");
        for (int v = 0; v < 4; v++) begin
            waitCond(vecs[v].when, 0, 100, "vec_wait_timeout");
            pop_log.delete();
            applyStimulus(1'b1, vecs[v].rpc, 1'b1);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b1);
            waitCond(K_POPS, 2, 200, "vec_pop_timeout");
            if (pop_log.size() >= 2) begin
                checkOutput("vec_pc0", pop_log[0].pc, vecs[v].pc0);
                checkOutput("vec_instr0", pop_log[0].instr, vecs[v].instr0);
                checkOutput("vec_pc1", pop_log[1].pc, vecs[v].pc1);
                checkOutput("vec_instr1", pop_log[1].instr, vecs[v].instr1);
            end
        end

        $display("[TB] redirect in WAIT_HI squashes the in-flight word");
        tick();
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitCond(K_BUSY3, 0, 100, "waithi_timeout");
        pop_log.delete();
        applyStimulus(1'b1, 32'h40, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitCond(K_POPS, 1, 200, "squash_pop_timeout");
        if (pop_log.size() >= 1) begin
            checkOutput("squash_next_pc", pop_log[0].pc, 32'h40);
            checkOutput("squash_next_instr", pop_log[0].instr, 32'h110);
        end
        checkOutput("squash_stat", stat_squashes, statExpected(1));

        $display("[TB] full buffer throttles requests");
        tick();
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (120) tick();
        checkOutput("full_accepts", 32'(accepts), 32'd4);
        hi_count = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_enable) hi_count++;
        end
        checkOutput("full_enable_low", 32'(hi_count), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (60) tick();
        checkOutput("full_one_more_accept", 32'(accepts), 32'd5);

        $display("[TB] redirect with full buffer and simultaneous pop");
        a0 = accepts;
        applyStimulus(1'b1, 32'h23, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("redir_full_empty", 32'(out_valid), 32'h0);
        waitCond(K_ACCEPTS, a0 + 1, 20, "redir_full_accept_timeout");
        checkOutput("redir_full_addr", 32'(last_acc_addr), 32'h20);

        $display("[TB] controller delays ready before accept");
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitCond(K_BUSY, 0, 50, "delay_busy_timeout");
        ready_delay   = 3;
        stall_cycles  = 0;
        addr_unstable = 0;
        a0 = accepts;
        waitCond(K_ACCEPTS, a0 + 1, 100, "delay_accept_timeout");
        checkOutput("delay_stall_cycles", 32'(stall_cycles), 32'd3);
        checkOutput("delay_addr_stable", 32'(addr_unstable), 32'd0);

        $display("[TB] async reset in WAIT_LO");
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitCond(K_OVER, 0, 50, "wlo_timeout");
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitCond(K_ACCEPTS, 1, 20, "post_reset_accept_timeout");
        checkOutput("post_reset_addr", 32'(last_acc_addr), 32'(RESET_PC[ADDR_W-1:0]));
        waitCond(K_POPS, 1, 50, "post_reset_pop_timeout");
        if (pop_log.size() >= 1) begin
            checkOutput("post_reset_pc", pop_log[0].pc, RESET_PC);
            checkOutput("post_reset_instr", pop_log[0].instr, 32'h100);
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
